// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the clock-plus-data serial receiver.
// The state enum is also visible on the receiver's debug output.
package serial_rx_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT    = 2'd1,
      WAIT_SMP = 2'd2
   } rx_state_t;

   function automatic int bit_cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_data_rx_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input, plus a one-cycle
// pulse on the selected transition of the synchronized signal.
module sync_edge_det #(
   parameter int   STAGES = 2,
   parameter logic EDGE   = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out,
   output logic edge_pulse
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_in};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign sync_out   = sync_q[STAGES-1];
   assign edge_pulse = (sync_out != prev_q) && (sync_out == EDGE);

endmodule

// File: rtl/serial_data_rx.sv
// Deserializes an asynchronous serial clock/data pair into DATA_WIDTH-bit
// words presented on a valid/ready handshake in the system-clock domain.
module serial_data_rx
   import serial_rx_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int MSB_FIRST   = 1,
   parameter int SAMPLE_EDGE = 1,
   parameter int SAMPLE_DLY  = 1,
   parameter int SYNC_STAGES = 2,
   parameter int IDLE_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ser_clk,
   input  logic                  ser_data,
   input  logic                  rx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  rx_busy,
   output logic                  frame_err,
   output logic                  overrun,
   output rx_state_t             dbg_state
);

   // Handshake: rx_data is held stable while rx_valid=1; a word is consumed
   // in any cycle with rx_valid && rx_ready, and rx_valid then clears on the
   // next edge unless a newly completed frame reloads it in that same cycle.

   localparam int CNT_W  = bit_cnt_w(DATA_WIDTH);
   localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_WIDTH - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);
   localparam logic [1:0]        DLY_LOAD = 2'((SAMPLE_DLY > 0) ? SAMPLE_DLY - 1 : 0);

   logic                  sync_clk_unused;
   logic                  smp_edge;
   logic                  sync_data;
   logic                  data_edge_unused;

   rx_state_t             state;
   rx_state_t             next_state;
   logic [1:0]            dly_cnt;
   logic [CNT_W-1:0]      bit_cnt;
   logic [IDLE_W-1:0]     idle_cnt;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  frame_done;

   logic                  capture;
   logic                  load_dly;
   logic                  timeout;
   logic                  last_bit;

   sync_edge_det #(
      .STAGES (SYNC_STAGES),
      .EDGE   (SAMPLE_EDGE != 0)
   ) u_clk_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .async_in   (ser_clk),
      .sync_out   (sync_clk_unused),
      .edge_pulse (smp_edge)
   );

   // Same depth as the clock path so data and clock stay aligned.
   sync_edge_det #(
      .STAGES (SYNC_STAGES),
      .EDGE   (1'b1)
   ) u_data_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .async_in   (ser_data),
      .sync_out   (sync_data),
      .edge_pulse (data_edge_unused)
   );

   assign last_bit = (bit_cnt == LAST_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      capture    = 1'b0;
      load_dly   = 1'b0;
      timeout    = 1'b0;
      case (state)
         IDLE, SHIFT: begin
            if (smp_edge) begin
               if (SAMPLE_DLY == 0) begin
                  capture = 1'b1;
               end else begin
                  load_dly   = 1'b1;
                  next_state = WAIT_SMP;
               end
            end else if ((state == SHIFT) && (idle_cnt == IDLE_MAX)) begin
               timeout    = 1'b1;
               next_state = IDLE;
            end
         end
         WAIT_SMP: begin
            // Sample edges seen here violate serial timing and are ignored.
            if (dly_cnt == 2'd0) begin
               capture = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
      if (capture) begin
         next_state = last_bit ? IDLE : SHIFT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dly_cnt    <= 2'd0;
         bit_cnt    <= '0;
         idle_cnt   <= '0;
         shreg      <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= capture && last_bit;
         frame_err  <= timeout;

         if (load_dly) begin
            dly_cnt <= DLY_LOAD;
         end else if ((state == WAIT_SMP) && (dly_cnt != 2'd0)) begin
            dly_cnt <= dly_cnt - 2'd1;
         end

         if (smp_edge) begin
            idle_cnt <= '0;
         end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
         end

         if (timeout) begin
            bit_cnt <= '0;
            shreg   <= '0;
         end else if (capture) begin
            if (MSB_FIRST != 0) begin
               shreg <= {shreg[DATA_WIDTH-2:0], sync_data};
            end else begin
               shreg <= {sync_data, shreg[DATA_WIDTH-1:1]};
            end
            bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
         end
      end
   end

   // Output word register: a completed frame is dropped if the previous
   // word is still pending and not being consumed this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (frame_done) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shreg;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign rx_busy   = (bit_cnt != '0) || (state == WAIT_SMP);
   assign dbg_state = state;

endmodule

// File: tb/tb_serial_data_rx.sv
// Directed bench for serial_data_rx: three parameterizations share one
// serial stimulus; a monitor scores accepted words against an expected queue.
module tb_serial_data_rx;
   import serial_rx_pkg::*;

   localparam int W    = 8;
   localparam int SYNC = 2;
   localparam int DLY  = 1;

   logic         clk;
   logic         rst_n;
   logic         ser_clk;
   logic         ser_data;
   logic         rx_ready;

   logic [W-1:0] rx_data_a   [3];
   logic         rx_valid_a  [3];
   logic         rx_busy_a   [3];
   logic         frame_err_a [3];
   logic         overrun_a   [3];
   rx_state_t    st_a        [3];

   int           n_tests = 0;
   int           n_fail  = 0;
   int           n_acc   = 0;
   int           n_ferr  = 0;
   int           n_ovr   = 0;
   int           sel     = 0;
   logic [W-1:0] exp_q[$];

   // 0: MSB-first rising, 1: LSB-first rising, 2: MSB-first falling
   serial_data_rx #(.DATA_WIDTH(W), .MSB_FIRST(1), .SAMPLE_EDGE(1), .SAMPLE_DLY(DLY),
                    .SYNC_STAGES(SYNC), .IDLE_CYCLES(64)) u_msb (
      .clk(clk), .rst_n(rst_n), .ser_clk(ser_clk), .ser_data(ser_data), .rx_ready(rx_ready),
      .rx_data(rx_data_a[0]), .rx_valid(rx_valid_a[0]), .rx_busy(rx_busy_a[0]),
      .frame_err(frame_err_a[0]), .overrun(overrun_a[0]), .dbg_state(st_a[0]));

   serial_data_rx #(.DATA_WIDTH(W), .MSB_FIRST(0), .SAMPLE_EDGE(1), .SAMPLE_DLY(DLY),
                    .SYNC_STAGES(SYNC), .IDLE_CYCLES(64)) u_lsb (
      .clk(clk), .rst_n(rst_n), .ser_clk(ser_clk), .ser_data(ser_data), .rx_ready(rx_ready),
      .rx_data(rx_data_a[1]), .rx_valid(rx_valid_a[1]), .rx_busy(rx_busy_a[1]),
      .frame_err(frame_err_a[1]), .overrun(overrun_a[1]), .dbg_state(st_a[1]));

   serial_data_rx #(.DATA_WIDTH(W), .MSB_FIRST(1), .SAMPLE_EDGE(0), .SAMPLE_DLY(DLY),
                    .SYNC_STAGES(SYNC), .IDLE_CYCLES(64)) u_fall (
      .clk(clk), .rst_n(rst_n), .ser_clk(ser_clk), .ser_data(ser_data), .rx_ready(rx_ready),
      .rx_data(rx_data_a[2]), .rx_valid(rx_valid_a[2]), .rx_busy(rx_busy_a[2]),
      .frame_err(frame_err_a[2]), .overrun(overrun_a[2]), .dbg_state(st_a[2]));

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs move 2ns after a rising edge, so negedge sampling sees settled values.
   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(2);
   endtask

   task automatic send_bit(input logic b, input bit fall);
      if (!fall) begin
         ser_data = b;
         #50 ser_clk = 1'b1;
         #50 ser_clk = 1'b0;
      end else begin
         ser_data = b;
         ser_clk  = 1'b1;
         #50 ser_clk = 1'b0;
         #50;
      end
   endtask

   task automatic send_frame(input logic [W-1:0] w, input bit msb);
      for (int i = 0; i < W; i++) begin
         send_bit(msb ? w[W-1-i] : w[i], 1'b0);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid_a[sel] && rx_ready) begin
            n_acc++;
            if (exp_q.size() == 0) begin
               check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
               check("rx_data", 32'(rx_data_a[sel]), 32'(exp_q.pop_front()));
            end
         end
         if (frame_err_a[sel]) n_ferr++;
         if (overrun_a[sel])   n_ovr++;
      end
   end

   initial begin
      int a0, f0, o0, lat;
      rst_n    = 1'b0;
      ser_clk  = 1'b0;
      ser_data = 1'b0;
      rx_ready = 1'b1;
      wait_cyc(3);

      // reset values of all three instances
      for (int i = 0; i < 3; i++) begin
         check("rst_data",  32'(rx_data_a[i]),   32'd0);
         check("rst_valid", 32'(rx_valid_a[i]),  32'd0);
         check("rst_busy",  32'(rx_busy_a[i]),   32'd0);
         check("rst_ferr",  32'(frame_err_a[i]), 32'd0);
         check("rst_ovr",   32'(overrun_a[i]),   32'd0);
         check("rst_state", 32'(st_a[i]),        32'(IDLE));
      end
      rst_n = 1'b1;
      wait_cyc(2);

      // MSB-first 0xA5
      sel = 0;
      a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      wait_cyc(20);
      check("msb_count", 32'(n_acc - a0), 32'd1);
      check("msb_ferr",  32'(n_ferr - f0), 32'd0);
      check("msb_ovr",   32'(n_ovr - o0), 32'd0);
      check("msb_sb",    32'(exp_q.size()), 32'd0);

      // LSB-first 0x85, three frames with 150ns gaps
      do_reset();
      sel = 1;
      a0 = n_acc;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(8'h85);
         send_frame(8'h85, 1'b0);
         #150;
      end
      wait_cyc(20);
      check("lsb_count", 32'(n_acc - a0), 32'd3);
      check("lsb_sb",    32'(exp_q.size()), 32'd0);

      // backpressure: 0x3C held, 0xC3 dropped
      do_reset();
      sel = 0;
      rx_ready = 1'b0;
      a0 = n_acc; o0 = n_ovr;
      send_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1);
      wait_cyc(20);
      check("bp_valid", 32'(rx_valid_a[0]), 32'd1);
      check("bp_data",  32'(rx_data_a[0]),  32'h3C);
      check("bp_ovr",   32'(n_ovr - o0),    32'd1);
      exp_q.push_back(8'h3C);
      rx_ready = 1'b1;
      wait_cyc(1);
      check("bp_clear", 32'(rx_valid_a[0]), 32'd0);
      check("bp_count", 32'(n_acc - a0),    32'd1);
      check("bp_sb",    32'(exp_q.size()),  32'd0);

      // idle timeout after 3 bits, then a clean 0x5A
      do_reset();
      a0 = n_acc; f0 = n_ferr;
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      check("to_busy",  32'(rx_busy_a[0]), 32'd1);
      check("to_early", 32'(n_ferr - f0),  32'd0);
      wait_cyc(70);
      check("to_ferr",  32'(n_ferr - f0),  32'd1);
      check("to_idle",  32'(rx_busy_a[0]), 32'd0);
      check("to_state", 32'(st_a[0]),      32'(IDLE));
      check("to_noval", 32'(n_acc - a0),   32'd0);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      wait_cyc(20);
      check("to_next",  32'(n_acc - a0),   32'd1);

      // asynchronous reset mid-frame, then 0xF0
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      check("mr_busy_pre", 32'(rx_busy_a[0]), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("mr_data",  32'(rx_data_a[0]),   32'd0);
      check("mr_valid", 32'(rx_valid_a[0]),  32'd0);
      check("mr_busy",  32'(rx_busy_a[0]),   32'd0);
      check("mr_ferr",  32'(frame_err_a[0]), 32'd0);
      check("mr_ovr",   32'(overrun_a[0]),   32'd0);
      check("mr_state", 32'(st_a[0]),        32'(IDLE));
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(2);
      a0 = n_acc;
      exp_q.push_back(8'hF0);
      send_frame(8'hF0, 1'b1);
      wait_cyc(20);
      check("mr_count", 32'(n_acc - a0),  32'd1);
      check("mr_sb",    32'(exp_q.size()), 32'd0);

      // falling-edge sampling of 0x96 with latency measurement
      do_reset();
      sel = 2;
      a0 = n_acc;
      lat = 0;
      exp_q.push_back(8'h96);
      for (int i = 0; i < W - 1; i++) begin
         logic [W-1:0] w;
         w = 8'h96;
         send_bit(w[W-1-i], 1'b1);
      end
      ser_data = 1'b0;
      ser_clk  = 1'b1;
      #50 ser_clk = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (rx_valid_a[2]) begin
            lat = k;
            break;
         end
      end
      check("fall_latency", 32'(lat), 32'(SYNC + DLY + 2));
      wait_cyc(10);
      check("fall_count", 32'(n_acc - a0),  32'd1);
      check("fall_sb",    32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_data_rx.md
Name: serial_data_rx

Overview:
- Synthesizable receiver for the clock-plus-data serial link used by the team's serial stimulus generators.
- Samples an external serial clock and data pair, which are asynchronous to the system clock, and deserializes DATA_WIDTH-bit frames, MSB- or LSB-first.
- Presents each word on a valid/ready handshake.
- Sits at the boundary between bench/lab serial sources and the system-clock domain.

Parameters:
- DATA_WIDTH, 8: bits per frame.
- MSB_FIRST, 1: 1 means the first received bit lands in bit DATA_WIDTH-1; 0 means it lands in bit 0.
- SAMPLE_EDGE, 1: 1 samples on the ser_clk rising edge; 0 samples on the falling edge.
- SAMPLE_DLY, 1: system cycles between the detected edge and the data capture (0..3).
- SYNC_STAGES, 2: synchronizer depth for ser_clk and ser_data (>=2).
- IDLE_CYCLES, 64: system cycles with no sample edge before a partial frame is aborted.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- ser_clk, in, 1: serial clock, asynchronous.
- ser_data, in, 1: serial data, asynchronous.
- rx_ready, in, 1: consumer accepts rx_data.
- rx_data, out, DATA_WIDTH: received word.
- rx_valid, out, 1: rx_data holds an unconsumed word.
- rx_busy, out, 1: frame in progress (at least one bit received).
- frame_err, out, 1: one-cycle pulse when a partial frame is aborted by timeout.
- overrun, out, 1: one-cycle pulse when a completed word is dropped.

Behaviour:
- **Reset.** rst_n is asserted asynchronously. While asserted: rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0, state=IDLE, bit counter=0, idle counter=0, synchronizer flops=0.
- **Synchronization.** ser_clk and ser_data each pass through SYNC_STAGES flops, which keeps them aligned. A further flop on ser_clk gives the edge detector.
- **Sample edge.** Detected in the cycle where sync_clk != prev_clk and sync_clk == SAMPLE_EDGE.
- **Data capture.** The synchronized data is captured SAMPLE_DLY cycles after the detected edge, using a small delay counter or shift pipe.
- **Serial-side timing requirement.** Each serial half-period must be at least SAMPLE_DLY+3 system cycles. Behaviour is undefined otherwise.
- **State machine.** States are IDLE, SHIFT and WAIT_SMP.
  - IDLE: a sample edge moves to WAIT_SMP (or captures immediately if SAMPLE_DLY=0).
  - WAIT_SMP: on the delay expiring, shift the bit in and increment the bit counter.
  - If the counter reaches DATA_WIDTH, the frame completes and the state goes to IDLE. Otherwise the state goes to SHIFT.
  - SHIFT: a sample edge goes to WAIT_SMP.
- **Shift direction.**
  - MSB_FIRST=1: shreg <= {shreg[W-2:0], bit}.
  - MSB_FIRST=0: shreg <= {bit, shreg[W-1:1]}.
- **Bit counter.** Width $clog2(DATA_WIDTH+1). Cleared on frame completion and on abort.
- **rx_busy.** High while the bit counter is nonzero or the state is WAIT_SMP.
- **Frame completion.** In the cycle after the last bit is captured:
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 in that same cycle: rx_data <= shreg and rx_valid <= 1.
  - If rx_valid=1 and rx_ready=0: the new word is discarded, rx_data is unchanged, and overrun pulses for 1 cycle.
- **Handshake.** rx_valid is held until a cycle with rx_valid && rx_ready, then it clears next cycle unless the same cycle also loads a new word. rx_data is stable while rx_valid=1.
- **Idle timeout.**
  - The idle counter resets on every sample edge and increments otherwise, saturating.
  - If the state is SHIFT and the counter reaches IDLE_CYCLES: the bit counter and shreg are cleared, the state goes to IDLE, and frame_err pulses for 1 cycle.
  - No error is raised in IDLE.
- **Non-sample edges.** The opposite edge is ignored.
- **Edge during WAIT_SMP.** A sample edge arriving in WAIT_SMP is a timing violation: it is ignored, and the spec makes no guarantee of correctness.
- **Latency.** rx_valid rises SYNC_STAGES+SAMPLE_DLY+2 cycles after the final sample edge on the pin (first clk edge after the pin change counted as cycle 1).

Decomposition:
- serial_rx_pkg holds:
  - the state enum rx_state_t {IDLE, SHIFT, WAIT_SMP};
  - a function bit_cnt_w(int w) returning $clog2(w+1).
- One sub-module, sync_edge_det. Parameters: STAGES, EDGE. Inputs: clk, rst_n, async_in. Outputs: sync_out, edge_pulse. It is instantiated for ser_clk; ser_data uses the same synchronizer with edge_pulse unused.

Test Plan:
- **MSB-first 0xA5.** clk=10ns, ser period 100ns, SAMPLE_EDGE=1, with data changing on or before each rising edge and rx_ready=1. Expected: one rx_valid pulse with rx_data=0xA5, frame_err=0, overrun=0.
- **LSB-first 0x85.** MSB_FIRST=0, bits sent 1,0,1,0,0,0,0,1. Expected: rx_data=0x85. Repeat three back-to-back frames with a 150ns gap; expected three valids, all 0x85.
- **Backpressure.** rx_ready=0 while two frames 0x3C then 0xC3 arrive. Expected: rx_valid stays high with rx_data=0x3C, and overrun pulses once at the second completion. Then raise rx_ready; expected rx_valid clears next cycle.
- **Timeout.** Send 3 bits, then hold ser_clk for 70 system cycles. Expected: frame_err pulses once at idle count 64, rx_busy drops, no rx_valid. The next full 0x5A frame is received correctly.
- **Reset mid-frame.** Assert rst_n low after 4 bits. Expected: all outputs 0 immediately, without waiting for a clock. After release, a full 0xF0 frame is received as 0xF0.
- **Falling-edge sampling.** SAMPLE_EDGE=0 with data changing on rising edges, frame 0x96. Expected: rx_data=0x96. Check the latency to rx_valid equals SYNC_STAGES+SAMPLE_DLY+2 cycles from the last falling edge.
